trng_seq_ctrl: RTL and testbench
================================

Name: trng_seq_ctrl

Overview:
Sequencer for the ring-oscillator TRNG datapath. It gates the ring enable, waits a warm-up period, and collects KEY_W raw random bits per key. It runs a repetition-count health test on the raw stream and delivers each key over a valid/ready handshake. It also emits the one-cycle sample strobe consumed by the key-sample/display path, and sits between the inverter-ring/post-process chain and the key consumer.

Parameters:
WARMUP_CYC, 64, clk cycles the ring runs before any bit is collected (min 1)
KEY_W, 4, bits per delivered key (min 1, max 16)
REP_LIMIT, 8, consecutive identical raw bits that trip the health test (min 2)

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-high
req  in  1  level request: keep generating keys while high
raw_bit  in  1  post-processed random bit, sampled every clk
ring_en  out  1  ring oscillator enable (drives startring)
sample_pulse  out  1  one-cycle strobe when a new key is latched
key_out  out  KEY_W  delivered key
key_valid  out  1  key_out holds an unconsumed key
key_ready  in  1  consumer accepts key when high with key_valid
busy  out  1  high in any state other than IDLE
health_fail  out  1  sticky health-test failure flag
fail_clr  in  1  clears health_fail and leaves FAIL

Behaviour:
- Reset (rst_n=1, async): state=IDLE. ring_en, sample_pulse, key_valid, busy and health_fail are 0. key_out, shift register, warm-up counter, bit counter and repetition counter are 0. Reset mid-operation aborts immediately and discards any partial key.
- All outputs are registered.
- IDLE: if req=1 → WARMUP. ring_en=1 and warm-up counter=0 from the next cycle. Repetition counter cleared.
- WARMUP: counter increments each cycle. On the cycle the counter reaches WARMUP_CYC-1 → COLLECT. If req drops during WARMUP → IDLE with ring_en=0.
- COLLECT: raw_bit is shifted in each cycle, new bit into LSB, shift left. After the KEY_W-th bit → HOLD. On the same edge: key_out is loaded with the full word, key_valid=1, and sample_pulse=1 for exactly one cycle. Latency from COLLECT entry to key_valid is KEY_W cycles. req is ignored mid-key; a started key always completes.
- HOLD: ring_en stays 1. No bits are collected and the repetition counter is frozen. key_out and key_valid stay stable until key_valid&key_ready.
  - On accept with req=1 → COLLECT, with no re-warm-up.
  - On accept with req=0 → IDLE with ring_en=0.
  - key_valid drops on the cycle after accept.
- Health test runs in COLLECT only. It tracks the last raw bit and a run length that saturates at REP_LIMIT.
  - Same bit: run+1. Different bit: run=1.
  - When run reaches REP_LIMIT → FAIL and the partial key is discarded. ring_en=0, key_valid=0, health_fail=1.
  - A trip on the KEY_W-th bit takes priority: no key is delivered.
- FAIL: holds until fail_clr=1, then → IDLE and health_fail=0 next cycle. req is ignored in FAIL. fail_clr outside FAIL has no effect.
- Simultaneous events: rst_n dominates everything. fail_clr and req both high in FAIL → IDLE first; WARMUP starts one cycle later.
- busy = (state != IDLE).

Optional Feature:
TRNG_DEBIAS_EN:
- Defined: a von Neumann corrector is inserted before the shift register. Raw bits are paired on consecutive COLLECT cycles.
  - 01 → emit 0; 10 → emit 1; 00/11 → discard.
  - Only emitted bits count toward KEY_W, so key latency becomes variable, at least 2*KEY_W cycles.
  - The health test still runs on raw bits.
  - A pair half-collected at HOLD entry is discarded.
- Undefined: every raw bit is used directly, with fixed latency KEY_W.

Test Plan:
1. WARMUP_CYC=8, KEY_W=4; reset, then req=1, key_ready=1, raw_bit stream 1,0,1,1 after warm-up → ring_en rises 1 cycle after req. key_valid rises 8+4 cycles later with key_out=4'b1011 and a single-cycle sample_pulse.
2. key_ready=0 for 20 cycles after key_valid → key_out and key_valid stable for all 20 cycles. Raise key_ready with req=1 → next key is collected without re-warm-up (key_valid again after 4+1 cycles).
3. REP_LIMIT=8, raw_bit held 0 in COLLECT → health_fail=1 and ring_en=0 after 8 collected bits, with no key_valid. fail_clr pulse → state IDLE, health_fail=0.
4. req dropped during WARMUP at cycle 3 → ring_en=0 and busy=0 next cycle, no sample_pulse.
5. rst_n pulsed mid-COLLECT after 2 bits → all outputs 0 asynchronously. After release with req=1 → full warm-up repeats and the first key uses only new bits.
6. With TRNG_DEBIAS_EN: raw pairs 01,11,10,00,10,01 → key_out=4'b0110 after 12 collect cycles.

Source files
------------

// File: rtl/trng_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : trng_seq_ctrl                                                |
// | Description : Ring-oscillator TRNG sequencer: warm-up, key collection,     |
// |               repetition-count health test, valid/ready key delivery.      |
// |               Optional von Neumann corrector under `TRNG_DEBIAS_EN.        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module trng_seq_ctrl #(
    parameter int WARMUP_CYC = 64,
    parameter int KEY_W      = 4,
    parameter int REP_LIMIT  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic             raw_bit,
    output logic             ring_en,
    output logic             sample_pulse,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             busy,
    output logic             health_fail,
    input  logic             fail_clr
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_WARMUP  = 3'd1;
    localparam logic [2:0] c_ST_COLLECT = 3'd2;
    localparam logic [2:0] c_ST_HOLD    = 3'd3;
    localparam logic [2:0] c_ST_FAIL    = 3'd4;

    localparam int c_WARM_W = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
    localparam int c_RUN_W  = $clog2(REP_LIMIT + 1);

    localparam logic [c_WARM_W-1:0] c_WARM_LAST = c_WARM_W'(WARMUP_CYC - 1);
    localparam logic [4:0]          c_BIT_LAST  = 5'(KEY_W - 1);
    localparam logic [c_RUN_W-1:0]  c_RUN_LIMIT = c_RUN_W'(REP_LIMIT);
    localparam logic [c_RUN_W-1:0]  c_RUN_ONE   = c_RUN_W'(1);

    logic [2:0]          r_state;
    logic [KEY_W-1:0]    r_shift;
    logic [c_WARM_W-1:0] r_warm_cnt;
    logic [4:0]          r_bit_cnt;
    logic [c_RUN_W-1:0]  r_run;
    logic                r_last_bit;

    logic [c_RUN_W-1:0]  w_run_next;
    logic                w_rep_trip;
    logic                w_emit;
    logic                w_emit_bit;
    logic                w_key_done;
    logic [KEY_W-1:0]    w_word;

    // A zero run length means no raw bit has been seen since IDLE.
    always_comb begin
        w_run_next = c_RUN_ONE;
        if ((r_run != '0) && (raw_bit == r_last_bit)) begin
            w_run_next = (r_run == c_RUN_LIMIT) ? r_run : r_run + 1'b1;
        end
        w_rep_trip = (w_run_next == c_RUN_LIMIT);
    end

`ifdef TRNG_DEBIAS_EN
    logic r_pair_half;
    logic r_pair_first;

    assign w_emit     = r_pair_half && (raw_bit != r_pair_first);
    assign w_emit_bit = r_pair_first;

    // Pairing restarts whenever collection stops, so a half pair never leaks into the next key.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_pair_half  <= 1'b0;
            r_pair_first <= 1'b0;
        end else if ((r_state == c_ST_COLLECT) && !w_rep_trip && !w_key_done) begin
            r_pair_half <= ~r_pair_half;
            if (!r_pair_half) begin
                r_pair_first <= raw_bit;
            end
        end else begin
            r_pair_half <= 1'b0;
        end
    end
`else
    assign w_emit     = 1'b1;
    assign w_emit_bit = raw_bit;
`endif

    assign w_key_done = w_emit && (r_bit_cnt == c_BIT_LAST);

    generate
        if (KEY_W == 1) begin : g_word_single
            assign w_word = w_emit_bit;
        end else begin : g_word_shift
            assign w_word = {r_shift[KEY_W-2:0], w_emit_bit};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state      <= c_ST_IDLE;
            r_shift      <= '0;
            r_warm_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_run        <= '0;
            r_last_bit   <= 1'b0;
            ring_en      <= 1'b0;
            sample_pulse <= 1'b0;
            key_out      <= '0;
            key_valid    <= 1'b0;
            busy         <= 1'b0;
            health_fail  <= 1'b0;
        end else begin
            sample_pulse <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_run     <= '0;
                    r_bit_cnt <= '0;
                    if (req) begin
                        r_state    <= c_ST_WARMUP;
                        r_warm_cnt <= '0;
                        ring_en    <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                c_ST_WARMUP: begin
                    if (!req) begin
                        r_state <= c_ST_IDLE;
                        ring_en <= 1'b0;
                        busy    <= 1'b0;
                    end else if (r_warm_cnt == c_WARM_LAST) begin
                        r_state   <= c_ST_COLLECT;
                        r_bit_cnt <= '0;
                    end else begin
                        r_warm_cnt <= r_warm_cnt + 1'b1;
                    end
                end
                c_ST_COLLECT: begin
                    r_run      <= w_run_next;
                    r_last_bit <= raw_bit;
                    if (w_rep_trip) begin
                        r_state     <= c_ST_FAIL;
                        r_shift     <= '0;
                        r_bit_cnt   <= '0;
                        ring_en     <= 1'b0;
                        key_valid   <= 1'b0;
                        health_fail <= 1'b1;
                    end else if (w_emit) begin
                        r_shift <= w_word;
                        if (w_key_done) begin
                            r_state      <= c_ST_HOLD;
                            r_bit_cnt    <= '0;
                            key_out      <= w_word;
                            key_valid    <= 1'b1;
                            sample_pulse <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                c_ST_HOLD: begin
                    if (key_ready) begin
                        key_valid <= 1'b0;
                        if (req) begin
                            r_state <= c_ST_COLLECT;
                        end else begin
                            r_state <= c_ST_IDLE;
                            ring_en <= 1'b0;
                            busy    <= 1'b0;
                        end
                    end
                end
                c_ST_FAIL: begin
                    if (fail_clr) begin
                        r_state     <= c_ST_IDLE;
                        health_fail <= 1'b0;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= c_ST_IDLE;
                    ring_en   <= 1'b0;
                    key_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trng_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_trng_seq_ctrl                                             |
// | Description : Self-checking bench for trng_seq_ctrl (WARMUP 8, KEY 4,      |
// |               REP 8); honours `TRNG_DEBIAS_EN when built with it.          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_trng_seq_ctrl;

    localparam int c_W = 8;
    localparam int c_K = 4;
    localparam int c_R = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           req = 1'b0;
    logic           raw_bit = 1'b0;
    logic           ring_en;
    logic           sample_pulse;
    logic [c_K-1:0] key_out;
    logic           key_valid;
    logic           key_ready = 1'b0;
    logic           busy;
    logic           health_fail;
    logic           fail_clr = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    // Raw bits seen in COLLECT since the last IDLE, and bits to drive before random ones.
    bit hist[$];
    bit forced[$];

    trng_seq_ctrl #(
        .WARMUP_CYC (c_W),
        .KEY_W      (c_K),
        .REP_LIMIT  (c_R)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .raw_bit      (raw_bit),
        .ring_en      (ring_en),
        .sample_pulse (sample_pulse),
        .key_out      (key_out),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .busy         (busy),
        .health_fail  (health_fail),
        .fail_clr     (fail_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic ring, input logic sp,
                             input logic kv, input logic bz, input logic hf);
        chk({tag, ".ring_en"},      32'(ring_en),      32'(ring));
        chk({tag, ".sample_pulse"}, 32'(sample_pulse), 32'(sp));
        chk({tag, ".key_valid"},    32'(key_valid),    32'(kv));
        chk({tag, ".busy"},         32'(busy),         32'(bz));
        chk({tag, ".health_fail"},  32'(health_fail),  32'(hf));
    endtask

    task automatic start_req();
        req = 1'b1;
        tick();
        chk_state("req_rise", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        hist.delete();
        for (int i = 0; i < c_W; i++) begin
            raw_bit = 1'($urandom_range(0, 1));
            tick();
            chk("warmup.key_valid", 32'(key_valid), 32'd0);
            chk("warmup.ring_en", 32'(ring_en), 32'd1);
        end
    endtask

    // Drives raw bits until the model says a key completes or the health test trips.
    task automatic run_collect(output bit tripped, output logic [c_K-1:0] word);
        int  n = 0;
        int  cnt = 0;
        bit  done = 0;
        bit  b;
        bit  same;
        bit  e;
        bit  emit;
        bit  have = 0;
        bit  first = 0;
        tripped = 0;
        word = '0;
        while (!done) begin
            if (forced.size() > 0) b = forced.pop_front();
            else b = 1'($urandom_range(0, 1));
            raw_bit = b;
            tick();
            n++;
            hist.push_back(b);
            same = (hist.size() >= c_R);
            if (same) begin
                for (int i = 1; i < c_R; i++) begin
                    if (hist[hist.size() - 1 - i] != b) same = 0;
                end
            end
            if (same) begin
                chk_state("trip", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
                tripped = 1;
                done = 1;
            end else begin
`ifdef TRNG_DEBIAS_EN
                emit = 0;
                e = first;
                if (!have) begin
                    have = 1;
                    first = b;
                end else begin
                    have = 0;
                    emit = (b != first);
                end
`else
                emit = 1;
                e = b;
`endif
                if (emit) begin
                    word = {word[c_K-2:0], e};
                    cnt++;
                end
                if (cnt == c_K) begin
                    chk_state("deliver", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
                    chk("deliver.key_out", 32'(key_out), 32'(word));
                    done = 1;
                end else begin
                    chk("collect.key_valid", 32'(key_valid), 32'd0);
                    chk("collect.sample_pulse", 32'(sample_pulse), 32'd0);
                end
            end
            if (!done && n >= 200) begin
                n_cmp++;
                n_err++;
                $error("FAIL collect_timeout: observed no key after %0d cycles expected key", n);
                done = 1;
            end
        end
    endtask

    task automatic accept_keep();
        req = 1'b1;
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        chk_state("accept_keep", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic recover();
        req = 1'b0;
        fail_clr = 1'b1;
        tick();
        fail_clr = 1'b0;
        chk_state("recover", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin : main
        bit             t;
        bit             in_hold;
        logic [c_K-1:0] w;

        // Reset state
        repeat (3) tick();
        chk_state("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.key_out", 32'(key_out), 32'd0);
        rst_n = 1'b0;
        tick();
        chk_state("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // First key with a fixed raw stream
`ifdef TRNG_DEBIAS_EN
        forced = '{0, 1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 1};
`else
        forced = '{1, 0, 1, 1};
`endif
        start_req();
        run_collect(t, w);
        tick();
        chk("pulse_single", 32'(sample_pulse), 32'd0);

        // Key held stable while the consumer stalls
        for (int i = 0; i < 20; i++) begin
            raw_bit = 1'($urandom_range(0, 1));
            tick();
            chk("hold.key_valid", 32'(key_valid), 32'd1);
            chk("hold.key_out", 32'(key_out), 32'(w));
            chk("hold.ring_en", 32'(ring_en), 32'd1);
        end

        // Back-to-back random keys without re-warm-up
        in_hold = !t;
        for (int k = 0; k < 8; k++) begin
            if (in_hold) accept_keep();
            else begin
                recover();
                start_req();
            end
            run_collect(t, w);
            in_hold = !t;
        end
        if (in_hold) begin
            req = 1'b0;
            key_ready = 1'b1;
            tick();
            key_ready = 1'b0;
            chk_state("accept_stop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end else begin
            recover();
        end

        // Stuck-at-zero stream trips the health test
        start_req();
        repeat (16) forced.push_back(1'b0);
        run_collect(t, w);
        if (!t) begin
            accept_keep();
            run_collect(t, w);
        end
        forced.delete();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_state("fail_hold", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        end
        fail_clr = 1'b1;
        tick();
        fail_clr = 1'b0;
        chk_state("fail_clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_state("rewarm", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        req = 1'b0;
        tick();
        chk_state("rewarm_drop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Request dropped during warm-up
        req = 1'b1;
        tick();
        chk("warm_abort.rise", 32'(ring_en), 32'd1);
        tick();
        tick();
        req = 1'b0;
        tick();
        chk_state("warm_abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a key
`ifdef TRNG_DEBIAS_EN
        forced = '{1, 0, 1, 0, 0, 1, 1, 0};
`else
        forced = '{1, 1, 0, 1};
`endif
        start_req();
        run_collect(t, w);
        accept_keep();
        raw_bit = 1'b1;
        tick();
        raw_bit = 1'b0;
        tick();
        #2;
        rst_n = 1'b1;
        #1;
        chk_state("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("async_rst.key_out", 32'(key_out), 32'd0);
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        tick();
        chk_state("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef TRNG_DEBIAS_EN
        forced = '{0, 1, 1, 0, 1, 0, 0, 1};
`else
        forced = '{0, 1, 1, 0};
`endif
        start_req();
        run_collect(t, w);
        req = 1'b0;
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        chk_state("final_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
